// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target register block.
package i2c_target_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WRITE,
      ST_WRITE_ACK,
      ST_READ,
      ST_MACK,
      ST_IGNORE
   } state_e;

   // SDA output-enable levels: 0 pulls the line low, 1 releases it
   localparam logic ACK_LVL  = 1'b0;
   localparam logic NACK_LVL = 1'b1;

   localparam int unsigned BIT_CNT_W = 4;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer, stability filter and edge flags for one I2C line.
module i2c_line_filter #(
   parameter int unsigned FILTER_LEN = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic pad,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int unsigned CNT_W = 4;

   logic [1:0]       sync_q;
   logic [CNT_W-1:0] cnt_q;

   // A new level is accepted only after FILTER_LEN consecutive differing samples
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= 2'b11;
         cnt_q  <= '0;
         level  <= 1'b1;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], pad};
         rise   <= 1'b0;
         fall   <= 1'b0;
         if (sync_q[1] == level) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
            cnt_q <= '0;
            level <= sync_q[1];
            rise  <= sync_q[1];
            fall  <= ~sync_q[1];
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a byte-wide register file with auto-incrementing pointer,
// shared with fabric logic through a local read/write port.
module i2c_target_regs
   import i2c_target_pkg::*;
#(
   parameter logic [6:0]  I2C_ADDR   = 7'h42,
   parameter int unsigned NUM_REGS   = 16,
   parameter int unsigned FILTER_LEN = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        scl_pad_i,
   output logic                        scl_pad_o,
   output logic                        scl_padoen_o,
   input  logic                        sda_pad_i,
   output logic                        sda_pad_o,
   output logic                        sda_padoen_o,
   input  logic                        loc_we,
   input  logic [$clog2(NUM_REGS)-1:0] loc_addr,
   input  logic [7:0]                  loc_wdata,
   output logic [7:0]                  loc_rdata,
   output logic                        bus_wr_pulse,
   output logic [$clog2(NUM_REGS)-1:0] bus_wr_addr,
   output logic [7:0]                  bus_wr_data,
   output logic                        busy
);

   localparam int unsigned PTR_W = $clog2(NUM_REGS);

   logic scl_f, scl_rise, scl_fall;
   logic sda_f, sda_rise, sda_fall;
   logic start_c, stop_c;

   state_e               state_q, state_d;
   logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]           shift_q, shift_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d, ptr_inc;
   logic                 rw_q, rw_d;
   logic                 sda_oe_d, busy_d, wr_pulse_d;
   logic [PTR_W-1:0]     wr_addr_d;
   logic [7:0]           wr_data_d, rx_byte;
   logic                 byte_done;

   logic [7:0] regs [NUM_REGS];

   assign scl_pad_o    = 1'b0;
   assign scl_padoen_o = 1'b1;
   assign sda_pad_o    = 1'b0;

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
      .clk(clk), .reset(reset), .pad(scl_pad_i),
      .level(scl_f), .rise(scl_rise), .fall(scl_fall)
   );

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
      .clk(clk), .reset(reset), .pad(sda_pad_i),
      .level(sda_f), .rise(sda_rise), .fall(sda_fall)
   );

   assign start_c = sda_fall & scl_f;
   assign stop_c  = sda_rise & scl_f;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         shift_q      <= '0;
         ptr_q        <= '0;
         rw_q         <= 1'b0;
         sda_padoen_o <= NACK_LVL;
         busy         <= 1'b0;
         bus_wr_pulse <= 1'b0;
         bus_wr_addr  <= '0;
         bus_wr_data  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         shift_q      <= shift_d;
         ptr_q        <= ptr_d;
         rw_q         <= rw_d;
         sda_padoen_o <= sda_oe_d;
         busy         <= busy_d;
         bus_wr_pulse <= wr_pulse_d;
         bus_wr_addr  <= wr_addr_d;
         bus_wr_data  <= wr_data_d;
      end
   end

   // SDA only changes on a detected SCL fall; data is sampled on SCL rise
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      ptr_d      = ptr_q;
      rw_d       = rw_q;
      sda_oe_d   = sda_padoen_o;
      busy_d     = busy;
      wr_pulse_d = 1'b0;
      wr_addr_d  = bus_wr_addr;
      wr_data_d  = bus_wr_data;
      rx_byte    = {shift_q[6:0], sda_f};
      ptr_inc    = ptr_q + PTR_W'(1);
      byte_done  = (cnt_q == BIT_CNT_W'(7));

      if (start_c) begin
         state_d  = ST_ADDR;
         cnt_d    = '0;
         sda_oe_d = NACK_LVL;
      end else if (stop_c) begin
         state_d  = ST_IDLE;
         sda_oe_d = NACK_LVL;
         busy_d   = 1'b0;
      end else begin
         unique case (state_q)
            ST_ADDR, ST_PTR, ST_WRITE: begin
               if (scl_rise) begin
                  shift_d = rx_byte;
                  cnt_d   = cnt_q + BIT_CNT_W'(1);
                  if (byte_done) begin
                     cnt_d = '0;
                     if (state_q == ST_ADDR) begin
                        if (rx_byte[7:1] == I2C_ADDR) begin
                           state_d = ST_ADDR_ACK;
                           busy_d  = 1'b1;
                           rw_d    = rx_byte[0];
                        end else begin
                           state_d = ST_IGNORE;
                        end
                     end else if (state_q == ST_PTR) begin
                        ptr_d   = PTR_W'(rx_byte);
                        state_d = ST_PTR_ACK;
                     end else begin
                        wr_pulse_d = 1'b1;
                        wr_addr_d  = ptr_q;
                        wr_data_d  = rx_byte;
                        state_d    = ST_WRITE_ACK;
                     end
                  end
               end
            end
            // First fall drives the ACK, second fall ends the ACK clock
            ST_ADDR_ACK, ST_PTR_ACK, ST_WRITE_ACK: begin
               if (scl_fall) begin
                  if (cnt_q == '0) begin
                     sda_oe_d = ACK_LVL;
                     cnt_d    = BIT_CNT_W'(1);
                  end else begin
                     sda_oe_d = NACK_LVL;
                     cnt_d    = '0;
                     if (state_q == ST_ADDR_ACK && rw_q) begin
                        shift_d  = {regs[ptr_q][6:0], 1'b0};
                        sda_oe_d = regs[ptr_q][7];
                        cnt_d    = BIT_CNT_W'(1);
                        state_d  = ST_READ;
                     end else if (state_q == ST_ADDR_ACK) begin
                        state_d = ST_PTR;
                     end else if (state_q == ST_WRITE_ACK) begin
                        ptr_d   = ptr_inc;
                        state_d = ST_WRITE;
                     end else begin
                        state_d = ST_WRITE;
                     end
                  end
               end
            end
            ST_READ: begin
               if (scl_fall) begin
                  if (cnt_q == BIT_CNT_W'(8)) begin
                     sda_oe_d = NACK_LVL;
                     cnt_d    = '0;
                     state_d  = ST_MACK;
                  end else begin
                     sda_oe_d = shift_q[7];
                     shift_d  = {shift_q[6:0], 1'b0};
                     cnt_d    = cnt_q + BIT_CNT_W'(1);
                  end
               end
            end
            ST_MACK: begin
               if (scl_rise) begin
                  if (sda_f == ACK_LVL) begin
                     ptr_d   = ptr_inc;
                     shift_d = regs[ptr_inc];
                     cnt_d   = '0;
                     state_d = ST_READ;
                  end else begin
                     state_d = ST_IGNORE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Bus write is applied last so it wins a same-cycle collision
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
         loc_rdata <= '0;
      end else begin
         loc_rdata <= regs[loc_addr];
         if (loc_we) regs[loc_addr] <= loc_wdata;
         if (bus_wr_pulse) regs[bus_wr_addr] <= bus_wr_data;
      end
   end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bit-banged I2C master bench for i2c_target_regs with a transaction-level register model.
module tb_i2c_target_regs;
   import i2c_target_pkg::*;

   localparam int unsigned NUM_REGS = 16;
   localparam int unsigned AW       = 4;
   localparam int          Q        = 10;
   localparam logic [6:0]  TGT      = 7'h42;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          scl_m = 1'b1, sda_m = 1'b1;
   logic          scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o, sda_line;
   logic          loc_we = 1'b0;
   logic [AW-1:0] loc_addr = '0;
   logic [7:0]    loc_wdata = '0, loc_rdata;
   logic          bus_wr_pulse, busy;
   logic [AW-1:0] bus_wr_addr;
   logic [7:0]    bus_wr_data;

   int n_cmp = 0;
   int n_fail = 0;

   logic [7:0]      mdl_regs [NUM_REGS];
   logic [7:0]      tx_data [8];
   logic [7:0]      rx_data [8];
   logic [AW+7:0]   wr_q [$];
   int              oe_low_cnt = 0;
   int              busy_cnt = 0;

   always #5 clk = ~clk;

   assign sda_line = sda_m & (sda_padoen_o | sda_pad_o);

   i2c_target_regs #(.I2C_ADDR(TGT), .NUM_REGS(NUM_REGS), .FILTER_LEN(4)) dut (
      .clk(clk), .reset(reset),
      .scl_pad_i(scl_m), .scl_pad_o(scl_pad_o), .scl_padoen_o(scl_padoen_o),
      .sda_pad_i(sda_line), .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o),
      .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_rdata(loc_rdata),
      .bus_wr_pulse(bus_wr_pulse), .bus_wr_addr(bus_wr_addr), .bus_wr_data(bus_wr_data),
      .busy(busy)
   );

   always @(negedge clk) begin
      if (bus_wr_pulse) wr_q.push_back({bus_wr_addr, bus_wr_data});
      if (!sda_padoen_o) oe_low_cnt++;
      if (busy) busy_cnt++;
   end

   initial begin
      #900us;
      $display("FAIL watchdog: simulation exceeded time limit (got timeout, need finish)");
      $fatal(1);
   end

   // ---------------- bus master primitives ----------------
   task automatic quarter();
      repeat (Q) @(posedge clk);
   endtask

   task automatic bit_w(input logic b, input logic glitch);
      quarter(); sda_m = b; quarter(); scl_m = 1'b1;
      if (glitch) begin
         repeat (8) @(posedge clk); scl_m = 1'b0;
         repeat (2) @(posedge clk); scl_m = 1'b1;
         repeat (2*Q-10) @(posedge clk);
      end else begin
         quarter(); quarter();
      end
      scl_m = 1'b0;
   endtask

   task automatic bit_r(output logic b);
      quarter(); sda_m = 1'b1; quarter(); scl_m = 1'b1;
      quarter(); b = sda_line; quarter(); scl_m = 1'b0;
   endtask

   task automatic byte_w(input logic [7:0] d, input logic glitch, output logic nak);
      for (int i = 7; i >= 0; i--) bit_w(d[i], glitch);
      bit_r(nak);
   endtask

   task automatic byte_r(input logic mnak, output logic [7:0] d);
      logic b;
      d = '0;
      for (int i = 0; i < 8; i++) begin bit_r(b); d = {d[6:0], b}; end
      bit_w(mnak, 1'b0);
   endtask

   task automatic i2c_start();
      quarter(); sda_m = 1'b1; quarter(); scl_m = 1'b1;
      quarter(); sda_m = 1'b0; quarter(); scl_m = 1'b0;
   endtask

   task automatic i2c_stop();
      quarter(); sda_m = 1'b0; quarter(); scl_m = 1'b1;
      quarter(); sda_m = 1'b1; quarter();
   endtask

   task automatic wr_txn(input logic [6:0] a7, input logic [7:0] ptr, input int n,
                         input logic glitch, output logic [9:0] naks);
      logic nk;
      naks = '0;
      i2c_start();
      byte_w({a7, 1'b0}, glitch, nk); naks[0] = nk;
      byte_w(ptr, glitch, nk);        naks[1] = nk;
      for (int i = 0; i < n; i++) begin byte_w(tx_data[i], glitch, nk); naks[2+i] = nk; end
      i2c_stop();
   endtask

   task automatic rd_txn(input logic [7:0] ptr, input int n, input logic do_stop,
                         output logic [2:0] naks);
      logic nk;
      logic [7:0] d;
      i2c_start();
      byte_w({TGT, 1'b0}, 1'b0, nk); naks[0] = nk;
      byte_w(ptr, 1'b0, nk);         naks[1] = nk;
      i2c_start();
      byte_w({TGT, 1'b1}, 1'b0, nk); naks[2] = nk;
      for (int i = 0; i < n; i++) begin byte_r(i == n - 1, d); rx_data[i] = d; end
      if (do_stop) i2c_stop();
   endtask

   task automatic loc_write(input int a, input logic [7:0] d);
      @(negedge clk); loc_we = 1'b1; loc_addr = AW'(a); loc_wdata = d;
      @(negedge clk); loc_we = 1'b0;
      mdl_regs[a] = d;
   endtask

   task automatic loc_read(input int a, output logic [7:0] d);
      @(negedge clk); loc_addr = AW'(a);
      @(negedge clk); d = loc_rdata;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [7:0] d;
      n_cmp++; if (sda_padoen_o !== 1'b1) begin n_fail++; $display("FAIL reset_sda_oe: got %b need 1", sda_padoen_o); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b need 0", busy); end
      n_cmp++; if ({bus_wr_pulse, bus_wr_addr, bus_wr_data} !== '0) begin n_fail++;
         $display("FAIL reset_bus_wr: got %b/%h/%h need 0/0/0", bus_wr_pulse, bus_wr_addr, bus_wr_data); end
      n_cmp++; if (loc_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_loc_rdata: got %h need 00", loc_rdata); end
      n_cmp++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d need IDLE", dut.state_q); end
      for (int a = 0; a < int'(NUM_REGS); a++) begin
         loc_read(a, d);
         n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_reg[%0d]: got %h need 00", a, d); end
      end
   endtask

   task automatic test_write_burst();
      logic [9:0] naks;
      logic [7:0] d;
      int base = wr_q.size();
      int bbase = busy_cnt;
      tx_data[0] = 8'hA5; tx_data[1] = 8'h5A;
      wr_txn(TGT, 8'h03, 2, 1'b0, naks);
      n_cmp++; if (naks[3:0] !== 4'b0000) begin n_fail++; $display("FAIL burst_acks: got %b need 0000", naks[3:0]); end
      n_cmp++; if (wr_q.size() - base !== 2) begin n_fail++; $display("FAIL burst_pulses: got %0d need 2", wr_q.size() - base); end
      else begin
         n_cmp++; if (wr_q[base] !== {4'd3, 8'hA5}) begin n_fail++; $display("FAIL burst_pulse0: got %h need 3a5", wr_q[base]); end
         n_cmp++; if (wr_q[base+1] !== {4'd4, 8'h5A}) begin n_fail++; $display("FAIL burst_pulse1: got %h need 45a", wr_q[base+1]); end
      end
      mdl_regs[3] = 8'hA5; mdl_regs[4] = 8'h5A;
      loc_read(4, d);
      n_cmp++; if (d !== mdl_regs[4]) begin n_fail++; $display("FAIL burst_loc4: got %h need %h", d, mdl_regs[4]); end
      loc_read(3, d);
      n_cmp++; if (d !== mdl_regs[3]) begin n_fail++; $display("FAIL burst_loc3: got %h need %h", d, mdl_regs[3]); end
      n_cmp++; if (busy_cnt == bbase) begin n_fail++; $display("FAIL burst_busy_seen: got 0 busy cycles need >0"); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL burst_busy_after_stop: got %b need 0", busy); end
   endtask

   task automatic test_random_read();
      logic [2:0] naks;
      for (int a = 0; a < int'(NUM_REGS); a++) loc_write(a, 8'($urandom));
      rd_txn(8'h0F, 2, 1'b0, naks);
      n_cmp++; if (naks !== 3'b000) begin n_fail++; $display("FAIL rd_acks: got %b need 000", naks); end
      n_cmp++; if (rx_data[0] !== mdl_regs[15]) begin n_fail++; $display("FAIL rd_byte0: got %h need %h", rx_data[0], mdl_regs[15]); end
      n_cmp++; if (rx_data[1] !== mdl_regs[0]) begin n_fail++; $display("FAIL rd_byte1_wrap: got %h need %h", rx_data[1], mdl_regs[0]); end
      n_cmp++; if (sda_padoen_o !== 1'b1) begin n_fail++; $display("FAIL rd_release_after_nack: got %b need 1", sda_padoen_o); end
      i2c_stop();
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy_after_stop: got %b need 0", busy); end
   endtask

   task automatic test_random_burst();
      logic [9:0] naks;
      logic [2:0] rnaks;
      logic [7:0] ptr;
      int n, base, a;
      for (int it = 0; it < 3; it++) begin
         ptr  = 8'($urandom_range(0, 255));
         n    = $urandom_range(1, 4);
         base = wr_q.size();
         for (int i = 0; i < n; i++) tx_data[i] = 8'($urandom);
         wr_txn(TGT, ptr, n, 1'b0, naks);
         n_cmp++; if (naks !== '0) begin n_fail++; $display("FAIL rb_acks[%0d]: got %b need 0", it, naks); end
         n_cmp++; if (wr_q.size() - base !== n) begin n_fail++; $display("FAIL rb_pulses[%0d]: got %0d need %0d", it, wr_q.size() - base, n); end
         else for (int i = 0; i < n; i++) begin
            a = (int'(ptr) + i) % NUM_REGS;
            n_cmp++; if (wr_q[base+i] !== {AW'(a), tx_data[i]}) begin n_fail++;
               $display("FAIL rb_pulse[%0d.%0d]: got %h need %h", it, i, wr_q[base+i], {AW'(a), tx_data[i]}); end
         end
         for (int i = 0; i < n; i++) mdl_regs[(int'(ptr) + i) % NUM_REGS] = tx_data[i];
         rd_txn(ptr, n, 1'b1, rnaks);
         n_cmp++; if (rnaks !== 3'b000) begin n_fail++; $display("FAIL rb_rd_acks[%0d]: got %b need 000", it, rnaks); end
         for (int i = 0; i < n; i++) begin
            a = (int'(ptr) + i) % NUM_REGS;
            n_cmp++; if (rx_data[i] !== mdl_regs[a]) begin n_fail++;
               $display("FAIL rb_rd[%0d.%0d]: got %h need %h", it, i, rx_data[i], mdl_regs[a]); end
         end
      end
   endtask

   task automatic test_addr_mismatch();
      logic [9:0] naks;
      logic [6:0] a7;
      int wbase, obase, bbase;
      for (int it = 0; it < 3; it++) begin
         a7 = (it == 0) ? 7'h43 : 7'($urandom_range(0, 127));
         if (a7 == TGT) a7 = a7 + 7'd1;
         tx_data[0] = 8'($urandom);
         wbase = wr_q.size(); obase = oe_low_cnt; bbase = busy_cnt;
         wr_txn(a7, 8'($urandom), 1, 1'b0, naks);
         n_cmp++; if (naks[2:0] !== 3'b111) begin n_fail++; $display("FAIL mm_naks[%0d]: got %b need 111", it, naks[2:0]); end
         n_cmp++; if (oe_low_cnt != obase) begin n_fail++; $display("FAIL mm_sda_driven[%0d]: got %0d cycles need 0", it, oe_low_cnt - obase); end
         n_cmp++; if (wr_q.size() != wbase) begin n_fail++; $display("FAIL mm_wr_pulse[%0d]: got %0d need 0", it, wr_q.size() - wbase); end
         n_cmp++; if (busy_cnt != bbase) begin n_fail++; $display("FAIL mm_busy[%0d]: got %0d cycles need 0", it, busy_cnt - bbase); end
      end
   endtask

   task automatic test_glitch();
      logic [9:0] naks;
      logic [7:0] ptr, d;
      int base = wr_q.size();
      ptr = 8'($urandom_range(0, 15));
      tx_data[0] = 8'($urandom); tx_data[1] = 8'($urandom);
      wr_txn(TGT, ptr, 2, 1'b1, naks);
      n_cmp++; if (naks[3:0] !== 4'b0000) begin n_fail++; $display("FAIL gl_acks: got %b need 0000", naks[3:0]); end
      n_cmp++; if (wr_q.size() - base !== 2) begin n_fail++; $display("FAIL gl_pulses: got %0d need 2", wr_q.size() - base); end
      for (int i = 0; i < 2; i++) mdl_regs[(int'(ptr) + i) % NUM_REGS] = tx_data[i];
      for (int i = 0; i < 2; i++) begin
         loc_read((int'(ptr) + i) % NUM_REGS, d);
         n_cmp++; if (d !== tx_data[i]) begin n_fail++; $display("FAIL gl_reg[%0d]: got %h need %h", i, d, tx_data[i]); end
      end
   endtask

   task automatic test_collision();
      logic [9:0] naks;
      logic [7:0] d;
      logic hit;
      tx_data[0] = 8'h22;
      hit = 1'b0;
      fork
         wr_txn(TGT, 8'h03, 1, 1'b0, naks);
         begin : watch
            int k;
            k = 0;
            while (!bus_wr_pulse && k < 20000) begin @(negedge clk); k++; end
            hit = bus_wr_pulse;
            if (hit) begin
               loc_we = 1'b1; loc_addr = 4'd3; loc_wdata = 8'h11;
               @(negedge clk); loc_we = 1'b0;
            end
         end
      join
      n_cmp++; if (hit !== 1'b1) begin n_fail++; $display("FAIL col_pulse_seen: got %b need 1", hit); end
      mdl_regs[3] = 8'h22;
      loc_read(3, d);
      n_cmp++; if (d !== mdl_regs[3]) begin n_fail++; $display("FAIL col_reg3: got %h need %h", d, mdl_regs[3]); end
   endtask

   task automatic test_reset_read();
      logic nk;
      logic [9:0] naks;
      logic [2:0] rnaks;
      logic [7:0] d;
      int base;
      loc_write(5, 8'h3C);
      i2c_start();
      byte_w({TGT, 1'b0}, 1'b0, nk);
      byte_w(8'h05, 1'b0, nk);
      i2c_start();
      byte_w({TGT, 1'b1}, 1'b0, nk);
      for (int k = 0; k < 50 && sda_padoen_o; k++) @(negedge clk);
      n_cmp++; if (sda_padoen_o !== 1'b0) begin n_fail++; $display("FAIL rr_holding_low: got %b need 0", sda_padoen_o); end
      @(negedge clk); reset = 1'b1;
      @(negedge clk);
      n_cmp++; if (sda_padoen_o !== 1'b1) begin n_fail++; $display("FAIL rr_release: got %b need 1", sda_padoen_o); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_busy: got %b need 0", busy); end
      n_cmp++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL rr_state: got %0d need IDLE", dut.state_q); end
      reset = 1'b0;
      for (int a = 0; a < int'(NUM_REGS); a++) mdl_regs[a] = 8'h00;
      for (int a = 3; a < 6; a++) begin
         loc_read(a, d);
         n_cmp++; if (d !== mdl_regs[a]) begin n_fail++; $display("FAIL rr_reg[%0d]: got %h need %h", a, d, mdl_regs[a]); end
      end
      i2c_stop();
      base = wr_q.size();
      tx_data[0] = 8'($urandom);
      wr_txn(TGT, 8'h07, 1, 1'b0, naks);
      mdl_regs[7] = tx_data[0];
      n_cmp++; if (naks[2:0] !== 3'b000) begin n_fail++; $display("FAIL rr_next_acks: got %b need 000", naks[2:0]); end
      n_cmp++; if (wr_q.size() - base !== 1) begin n_fail++; $display("FAIL rr_next_pulse: got %0d need 1", wr_q.size() - base); end
      rd_txn(8'h07, 1, 1'b1, rnaks);
      n_cmp++; if (rx_data[0] !== mdl_regs[7]) begin n_fail++; $display("FAIL rr_next_read: got %h need %h", rx_data[0], mdl_regs[7]); end
   endtask

   initial begin
      for (int a = 0; a < int'(NUM_REGS); a++) mdl_regs[a] = 8'h00;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      test_reset();
      test_write_burst();
      test_random_read();
      test_random_burst();
      test_addr_mismatch();
      test_glitch();
      test_collision();
      test_reset_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
